cpu_seq_controller: RTL and testbench
=====================================

Name: cpu_seq_controller

Overview:
- Second-generation instruction sequencer for the RISC machine CPU; drives datapath, PC, instruction register and memory-interface control.
- Adds over the first generation: variable-latency memory handshake (mem_ready) with a parametrised timeout, illegal-instruction trapping, sticky fault reporting, and optional conditional branch.
- Sits between instruction decoder (opcode/op/cond_true) and datapath/memory.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory access waits for mem_ready before faulting (>=1).
- TO_W, $clog2(MEM_TIMEOUT+1), timeout counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opcode  in  3  IR[15:13]
- op  in  2  IR[12:11]
- cond_true  in  1  branch condition evaluated from status flags
- mem_ready  in  1  memory completed current MREAD/MWRITE this cycle
- mem_cmd  out  2  00 none, 01 read, 10 write
- addr_sel  out  1  1=PC drives mem address, 0=data-address register
- load_ir, load_pc, reset_pc, load_addr  out  1 each  register enables
- pc_sel  out  2  00 PC+1, 01 PC+1+sximm8
- vsel  out  2  00 mdata, 01 sximm8, 10 PC, 11 C
- nsel  out  3  one-hot: 001 Rn, 010 Rd, 100 Rm
- write, loada, loadb, loadc, loads, asel, bsel  out  1 each  datapath controls
- halted  out  1  in HALT
- fault  out  2  00 none, 01 illegal instruction, 10 memory timeout
- state  out  5  current state code (debug)

Behaviour:
- Registered state; Moore outputs decoded from state (plus opcode/op/cond_true/mem_ready where noted). Every output not listed for a state is 0.
- Reset: next state RST, fault=00, timeout counter=0. Reset dominates all activity, including a pending memory wait.
- RST: reset_pc=1, load_pc=1 -> IF1.
- IF1: mem_cmd=01, addr_sel=1. Wait while mem_ready=0. In the cycle mem_ready=1, load_ir=1 -> UPDATE_PC.
- UPDATE_PC: load_pc=1, pc_sel=00 -> DECODE.
- DECODE (no outputs) routes:
  - 110/10 -> WRITE_IMM
  - 110/00 -> LOAD_B
  - 101/11 -> LOAD_B
  - 101/other -> LOAD_A
  - 011, 100 -> LOAD_A
  - 111 -> HALT
  - 001 -> BRANCH (feature only)
  - anything else -> FAULT with fault=01
- WRITE_IMM: write, vsel=01, nsel=001 -> IF1.
- LOAD_A: loada, nsel=001. Next: LOAD_C for 011/100, else LOAD_B.
- LOAD_B: loadb, nsel=100 -> LOAD_C.
- LOAD_C: loadc=1.
  - asel=1 for 110/00 and 101/11; bsel=1 for 011/100.
  - loads=1 only for opcode 101.
  - Next: 101/01 (CMP) -> IF1; 011/100 -> LOAD_ADR; else WRITE_OUT.
- WRITE_OUT: write, vsel=11, nsel=010 -> IF1.
- LOAD_ADR: load_addr=1. Next: MEM_RD for 011, LOAD_B2 for 100.
- MEM_RD: mem_cmd=01, addr_sel=0. Waits on mem_ready. In the ready cycle: write=1, vsel=00, nsel=010 -> IF1.
- LOAD_B2: loadb, nsel=010 -> LOAD_C2.
- LOAD_C2: loadc, asel=1 -> MEM_WR.
- MEM_WR: mem_cmd=10, addr_sel=0. Waits on mem_ready -> IF1.
- Wait states (IF1, MEM_RD, MEM_WR):
  - Counter clears on entry and increments each cycle mem_ready=0.
  - If mem_ready=0 when counter==MEM_TIMEOUT-1 -> FAULT with fault=10; mem_cmd returns to 00.
  - mem_ready=1 in that same cycle wins: normal completion.
  - mem_ready outside wait states is ignored.
- HALT: halted=1, absorbing until reset.
- FAULT: all controls 0, fault held sticky, absorbing until reset.

Optional Feature:
- Macro CTRL_BRANCH_EN.
- Defined: opcode 001 -> BRANCH. BRANCH: if cond_true=1, load_pc=1 and pc_sel=01; otherwise no controls. Then -> IF1.
- Undefined: opcode 001 is illegal -> FAULT with fault=01. pc_sel is tied to 00.

Test Plan:
- Reset, then MOV R1,#5 (110/10) with mem_ready=1 in IF1 -> state sequence RST,IF1,UPDATE_PC,DECODE,WRITE_IMM,IF1. WRITE_IMM shows write=1, vsel=01, nsel=001.
- ADD (101/00), IF1 mem_ready delayed 3 cycles -> IF1 held 4 cycles with mem_cmd=01. Then LOAD_A, LOAD_B, LOAD_C (loads=1), WRITE_OUT (vsel=11).
- LDR (011), MEM_RD ready after 2 cycles -> one write pulse with vsel=00, nsel=010. STR (100) -> MEM_WR with mem_cmd=10, write=0 throughout.
- MEM_TIMEOUT=16, mem_ready stuck 0 in MEM_WR -> FAULT after 16 cycles, fault=10 held until reset. Repeat with mem_ready=1 on the 16th cycle -> normal return to IF1.
- Opcode 000 -> FAULT with fault=01. Opcode 111 -> halted=1 persists 20 cycles. Reset asserted during MEM_RD wait -> RST next cycle, fault=00.
- With CTRL_BRANCH_EN: opcode 001 with cond_true=1 -> load_pc=1, pc_sel=01. With cond_true=0 -> load_pc=0. Without the macro: opcode 001 -> fault=01.

Source files
------------

// File: rtl/cpu_seq_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_seq_controller_if                                                    |
// | Decoder-to-sequencer inputs and datapath/memory control outputs.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cpu_seq_controller_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       cond_true;
  logic       mem_ready;
  logic [1:0] mem_cmd;
  logic       addr_sel;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic       load_addr;
  logic [1:0] pc_sel;
  logic [1:0] vsel;
  logic [2:0] nsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       halted;
  logic [1:0] fault;
  logic [4:0] state;

  modport master (
    input  opcode, op, cond_true, mem_ready,
    output mem_cmd, addr_sel, load_ir, load_pc, reset_pc, load_addr, pc_sel,
           vsel, nsel, write, loada, loadb, loadc, loads, asel, bsel,
           halted, fault, state
  );

  modport slave (
    output opcode, op, cond_true, mem_ready,
    input  mem_cmd, addr_sel, load_ir, load_pc, reset_pc, load_addr, pc_sel,
           vsel, nsel, write, loada, loadb, loadc, loads, asel, bsel,
           halted, fault, state
  );
endinterface
`default_nettype wire

// File: rtl/cpu_seq_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_seq_controller                                                       |
// | Instruction sequencer with memory-ready timeout and sticky faults.       |
// | Optional conditional branch enabled by macro CTRL_BRANCH_EN.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpu_seq_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  cpu_seq_controller_if.master bus
);

  localparam logic [4:0] S_RST       = 5'd0;
  localparam logic [4:0] S_IF1       = 5'd1;
  localparam logic [4:0] S_UPDATE_PC = 5'd2;
  localparam logic [4:0] S_DECODE    = 5'd3;
  localparam logic [4:0] S_WRITE_IMM = 5'd4;
  localparam logic [4:0] S_LOAD_A    = 5'd5;
  localparam logic [4:0] S_LOAD_B    = 5'd6;
  localparam logic [4:0] S_LOAD_C    = 5'd7;
  localparam logic [4:0] S_WRITE_OUT = 5'd8;
  localparam logic [4:0] S_LOAD_ADR  = 5'd9;
  localparam logic [4:0] S_MEM_RD    = 5'd10;
  localparam logic [4:0] S_LOAD_B2   = 5'd11;
  localparam logic [4:0] S_LOAD_C2   = 5'd12;
  localparam logic [4:0] S_MEM_WR    = 5'd13;
  localparam logic [4:0] S_HALT      = 5'd14;
  localparam logic [4:0] S_FAULT     = 5'd15;
  localparam logic [4:0] S_BRANCH    = 5'd16;

  localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TIMEOUT - 1);

  logic [4:0]      r_state;
  logic [4:0]      w_next;
  logic [TO_W-1:0] r_cnt;
  logic [1:0]      r_fault;
  logic            w_wait;
  logic            w_timeout;
  logic            w_mem_op;
  logic            w_asel_op;

  assign w_wait    = (r_state == S_IF1) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout = w_wait && !bus.mem_ready && (r_cnt == c_to_last);
  assign w_mem_op  = (bus.opcode == 3'b011) || (bus.opcode == 3'b100);
  assign w_asel_op = ({bus.opcode, bus.op} == 5'b110_00) || ({bus.opcode, bus.op} == 5'b101_11);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:       w_next = S_IF1;
      S_IF1:       if (bus.mem_ready) w_next = S_UPDATE_PC;
                   else if (w_timeout) w_next = S_FAULT;
      S_UPDATE_PC: w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          3'b110:  w_next = (bus.op == 2'b10) ? S_WRITE_IMM :
                            (bus.op == 2'b00) ? S_LOAD_B : S_FAULT;
          3'b101:  w_next = (bus.op == 2'b11) ? S_LOAD_B : S_LOAD_A;
          3'b011,
          3'b100:  w_next = S_LOAD_A;
          3'b111:  w_next = S_HALT;
`ifdef CTRL_BRANCH_EN
          3'b001:  w_next = S_BRANCH;
`endif
          default: w_next = S_FAULT;
        endcase
      end
      S_WRITE_IMM: w_next = S_IF1;
      S_LOAD_A:    w_next = w_mem_op ? S_LOAD_C : S_LOAD_B;
      S_LOAD_B:    w_next = S_LOAD_C;
      S_LOAD_C: begin
        if ({bus.opcode, bus.op} == 5'b101_01) w_next = S_IF1;
        else if (w_mem_op)                     w_next = S_LOAD_ADR;
        else                                   w_next = S_WRITE_OUT;
      end
      S_WRITE_OUT: w_next = S_IF1;
      S_LOAD_ADR:  w_next = (bus.opcode == 3'b011) ? S_MEM_RD : S_LOAD_B2;
      S_MEM_RD,
      S_MEM_WR:    if (bus.mem_ready) w_next = S_IF1;
                   else if (w_timeout) w_next = S_FAULT;
      S_LOAD_B2:   w_next = S_LOAD_C2;
      S_LOAD_C2:   w_next = S_MEM_WR;
      S_BRANCH:    w_next = S_IF1;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_FAULT;
    endcase
  end

  // Counter only advances while a wait state holds; any transition clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_fault <= 2'b00;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_wait && (w_next == r_state)) ? r_cnt + 1'b1 : '0;
      if (w_timeout)
        r_fault <= 2'b10;
      else if ((r_state == S_DECODE) && (w_next == S_FAULT))
        r_fault <= 2'b01;
    end
  end

  always_comb begin
    bus.mem_cmd   = 2'b00;
    bus.addr_sel  = 1'b0;
    bus.load_ir   = 1'b0;
    bus.load_pc   = 1'b0;
    bus.reset_pc  = 1'b0;
    bus.load_addr = 1'b0;
    bus.vsel      = 2'b00;
    bus.nsel      = 3'b000;
    bus.write     = 1'b0;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.halted    = 1'b0;
    case (r_state)
      S_RST:       begin bus.reset_pc = 1'b1; bus.load_pc = 1'b1; end
      S_IF1:       begin bus.mem_cmd = 2'b01; bus.addr_sel = 1'b1; bus.load_ir = bus.mem_ready; end
      S_UPDATE_PC: bus.load_pc = 1'b1;
      S_WRITE_IMM: begin bus.write = 1'b1; bus.vsel = 2'b01; bus.nsel = 3'b001; end
      S_LOAD_A:    begin bus.loada = 1'b1; bus.nsel = 3'b001; end
      S_LOAD_B:    begin bus.loadb = 1'b1; bus.nsel = 3'b100; end
      S_LOAD_C: begin
        bus.loadc = 1'b1;
        bus.asel  = w_asel_op;
        bus.bsel  = w_mem_op;
        bus.loads = (bus.opcode == 3'b101);
      end
      S_WRITE_OUT: begin bus.write = 1'b1; bus.vsel = 2'b11; bus.nsel = 3'b010; end
      S_LOAD_ADR:  bus.load_addr = 1'b1;
      S_MEM_RD: begin
        bus.mem_cmd = 2'b01;
        bus.write   = bus.mem_ready;
        bus.nsel    = bus.mem_ready ? 3'b010 : 3'b000;
      end
      S_LOAD_B2:   begin bus.loadb = 1'b1; bus.nsel = 3'b010; end
      S_LOAD_C2:   begin bus.loadc = 1'b1; bus.asel = 1'b1; end
      S_MEM_WR:    bus.mem_cmd = 2'b10;
`ifdef CTRL_BRANCH_EN
      S_BRANCH:    bus.load_pc = bus.cond_true;
`endif
      S_HALT:      bus.halted = 1'b1;
      default:     ;
    endcase
  end

`ifdef CTRL_BRANCH_EN
  assign bus.pc_sel = ((r_state == S_BRANCH) && bus.cond_true) ? 2'b01 : 2'b00;
`else
  assign bus.pc_sel = 2'b00;
`endif

  assign bus.fault = r_fault;
  assign bus.state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_seq_controller                                                    |
// | Vector table plus hand sequences, scoreboard-checked per cycle.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cpu_seq_controller;

  localparam logic [4:0] S_RST = 5'd0,  S_IF1 = 5'd1,  S_UPD = 5'd2,  S_DEC = 5'd3;
  localparam logic [4:0] S_WIMM = 5'd4, S_LA = 5'd5,   S_LB = 5'd6,   S_LC = 5'd7;
  localparam logic [4:0] S_WOUT = 5'd8, S_LADR = 5'd9, S_MRD = 5'd10, S_LB2 = 5'd11;
  localparam logic [4:0] S_LC2 = 5'd12, S_MWR = 5'd13, S_HALT = 5'd14, S_FAULT = 5'd15;
  localparam logic [4:0] S_BR = 5'd16;

  // Control word bit positions follow the packing in dut_ctl().
  localparam logic [23:0] C_WR   = 24'd1 << 23, C_RD   = 24'd1 << 22;
  localparam logic [23:0] C_ASRC = 24'd1 << 21, C_LIR  = 24'd1 << 20;
  localparam logic [23:0] C_LPC  = 24'd1 << 19, C_RPC  = 24'd1 << 18;
  localparam logic [23:0] C_LADR = 24'd1 << 17, C_PCB  = 24'd1 << 15;
  localparam logic [23:0] C_VIMM = 24'd1 << 13, C_VC   = 24'd3 << 13;
  localparam logic [23:0] C_NRN  = 24'd1 << 10, C_NRD  = 24'd1 << 11, C_NRM = 24'd1 << 12;
  localparam logic [23:0] C_WRT  = 24'd1 << 9,  C_LA   = 24'd1 << 8,  C_LB  = 24'd1 << 7;
  localparam logic [23:0] C_LC   = 24'd1 << 6,  C_LS   = 24'd1 << 5,  C_AS  = 24'd1 << 4;
  localparam logic [23:0] C_BS   = 24'd1 << 3,  C_HLT  = 24'd1 << 2;
  localparam logic [23:0] C_FIL  = 24'd1,       C_FTO  = 24'd2;
  localparam logic [23:0] C_NONE = 24'd0;

  typedef struct {
    logic       r;
    logic [2:0] opc;
    logic [1:0] op;
    logic       cnd;
    logic       rdy;
    logic [4:0] es;
    logic [23:0] ec;
  } vec_t;

  typedef struct {
    logic [4:0]  es;
    logic [23:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [2:0] cur_opc = 3'b000;
  logic [1:0] cur_op  = 2'b00;
  logic       cur_cnd = 1'b0;
  vec_t tbl[$];
  exp_t sb[$];

  cpu_seq_controller_if bus ();

  cpu_seq_controller #(.MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dut_ctl();
    return {bus.mem_cmd, bus.addr_sel, bus.load_ir, bus.load_pc, bus.reset_pc,
            bus.load_addr, bus.pc_sel, bus.vsel, bus.nsel, bus.write, bus.loada,
            bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel, bus.halted, bus.fault};
  endfunction

  task automatic step(input logic r, input logic [2:0] opc, input logic [1:0] op,
                      input logic cnd, input logic rdy, input logic [4:0] es,
                      input logic [23:0] ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = r;
    bus.opcode    = opc;
    bus.op        = op;
    bus.cond_true = cnd;
    bus.mem_ready = rdy;
    sb.push_back('{es: es, ec: ec});
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if (bus.state !== e.es) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", nm, bus.state, e.es);
    end
    n_tests++;
    if (dut_ctl() !== e.ec) begin
      n_fail++;
      $display("FAIL %s controls: got %06h expected %06h", nm, dut_ctl(), e.ec);
    end
  endtask

  task automatic st(input logic rdy, input logic [4:0] es, input logic [23:0] ec,
                    input string nm);
    step(1'b0, cur_opc, cur_op, cur_cnd, rdy, es, ec, nm);
  endtask

  task automatic add(input logic [2:0] opc, input logic [1:0] op, input logic rdy,
                     input logic [4:0] es, input logic [23:0] ec);
    tbl.push_back('{r: 1'b0, opc: opc, op: op, cnd: 1'b0, rdy: rdy, es: es, ec: ec});
  endtask

  task automatic fetch(input logic [2:0] opc, input logic [1:0] op, input string nm);
    cur_opc = opc;
    cur_op  = op;
    st(1'b1, S_IF1, C_RD | C_ASRC | C_LIR, {nm, "_if1"});
    st(1'b0, S_UPD, C_LPC, {nm, "_upd"});
    st(1'b1, S_DEC, C_NONE, {nm, "_dec"});
  endtask

  task automatic do_reset(input logic [4:0] es, input logic [23:0] ec, input string nm);
    step(1'b1, cur_opc, cur_op, cur_cnd, 1'b0, es, ec, {nm, "_rst_in"});
    st(1'b0, S_RST, C_RPC | C_LPC, {nm, "_rst_out"});
  endtask

  task automatic str_prefix(input string nm);
    fetch(3'b100, 2'b00, nm);
    st(1'b1, S_LA,   C_LA | C_NRN, {nm, "_la"});
    st(1'b1, S_LC,   C_LC | C_BS,  {nm, "_lc"});
    st(1'b1, S_LADR, C_LADR,       {nm, "_ladr"});
    st(1'b1, S_LB2,  C_LB | C_NRD, {nm, "_lb2"});
    st(1'b1, S_LC2,  C_LC | C_AS,  {nm, "_lc2"});
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 3'b000; bus.op = 2'b00; bus.cond_true = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // MOV R1,#5
    add(3'b110, 2'b10, 1'b1, S_RST,  C_RPC | C_LPC);
    add(3'b110, 2'b10, 1'b1, S_IF1,  C_RD | C_ASRC | C_LIR);
    add(3'b110, 2'b10, 1'b0, S_UPD,  C_LPC);
    add(3'b110, 2'b10, 1'b0, S_DEC,  C_NONE);
    add(3'b110, 2'b10, 1'b1, S_WIMM, C_WRT | C_VIMM | C_NRN);
    // ADD with fetch delayed three cycles
    add(3'b101, 2'b00, 1'b0, S_IF1,  C_RD | C_ASRC);
    add(3'b101, 2'b00, 1'b0, S_IF1,  C_RD | C_ASRC);
    add(3'b101, 2'b00, 1'b0, S_IF1,  C_RD | C_ASRC);
    add(3'b101, 2'b00, 1'b1, S_IF1,  C_RD | C_ASRC | C_LIR);
    add(3'b101, 2'b00, 1'b0, S_UPD,  C_LPC);
    add(3'b101, 2'b00, 1'b0, S_DEC,  C_NONE);
    add(3'b101, 2'b00, 1'b1, S_LA,   C_LA | C_NRN);
    add(3'b101, 2'b00, 1'b0, S_LB,   C_LB | C_NRM);
    add(3'b101, 2'b00, 1'b0, S_LC,   C_LC | C_LS);
    add(3'b101, 2'b00, 1'b0, S_WOUT, C_WRT | C_VC | C_NRD);
    // LDR, memory ready after two cycles
    add(3'b011, 2'b00, 1'b1, S_IF1,  C_RD | C_ASRC | C_LIR);
    add(3'b011, 2'b00, 1'b0, S_UPD,  C_LPC);
    add(3'b011, 2'b00, 1'b0, S_DEC,  C_NONE);
    add(3'b011, 2'b00, 1'b0, S_LA,   C_LA | C_NRN);
    add(3'b011, 2'b00, 1'b0, S_LC,   C_LC | C_BS);
    add(3'b011, 2'b00, 1'b1, S_LADR, C_LADR);
    add(3'b011, 2'b00, 1'b0, S_MRD,  C_RD);
    add(3'b011, 2'b00, 1'b0, S_MRD,  C_RD);
    add(3'b011, 2'b00, 1'b1, S_MRD,  C_RD | C_WRT | C_NRD);
    // STR
    add(3'b100, 2'b00, 1'b1, S_IF1,  C_RD | C_ASRC | C_LIR);
    add(3'b100, 2'b00, 1'b0, S_UPD,  C_LPC);
    add(3'b100, 2'b00, 1'b0, S_DEC,  C_NONE);
    add(3'b100, 2'b00, 1'b0, S_LA,   C_LA | C_NRN);
    add(3'b100, 2'b00, 1'b0, S_LC,   C_LC | C_BS);
    add(3'b100, 2'b00, 1'b0, S_LADR, C_LADR);
    add(3'b100, 2'b00, 1'b0, S_LB2,  C_LB | C_NRD);
    add(3'b100, 2'b00, 1'b0, S_LC2,  C_LC | C_AS);
    add(3'b100, 2'b00, 1'b0, S_MWR,  C_WR);
    add(3'b100, 2'b00, 1'b1, S_MWR,  C_WR);
    // CMP returns straight to fetch
    add(3'b101, 2'b01, 1'b1, S_IF1,  C_RD | C_ASRC | C_LIR);
    add(3'b101, 2'b01, 1'b0, S_UPD,  C_LPC);
    add(3'b101, 2'b01, 1'b0, S_DEC,  C_NONE);
    add(3'b101, 2'b01, 1'b0, S_LA,   C_LA | C_NRN);
    add(3'b101, 2'b01, 1'b0, S_LB,   C_LB | C_NRM);
    add(3'b101, 2'b01, 1'b0, S_LC,   C_LC | C_LS);
    // MOV Rd,Rm
    add(3'b110, 2'b00, 1'b1, S_IF1,  C_RD | C_ASRC | C_LIR);
    add(3'b110, 2'b00, 1'b0, S_UPD,  C_LPC);
    add(3'b110, 2'b00, 1'b0, S_DEC,  C_NONE);
    add(3'b110, 2'b00, 1'b0, S_LB,   C_LB | C_NRM);
    add(3'b110, 2'b00, 1'b0, S_LC,   C_LC | C_AS);
    add(3'b110, 2'b00, 1'b0, S_WOUT, C_WRT | C_VC | C_NRD);
    // MVN
    add(3'b101, 2'b11, 1'b1, S_IF1,  C_RD | C_ASRC | C_LIR);
    add(3'b101, 2'b11, 1'b0, S_UPD,  C_LPC);
    add(3'b101, 2'b11, 1'b0, S_DEC,  C_NONE);
    add(3'b101, 2'b11, 1'b0, S_LB,   C_LB | C_NRM);
    add(3'b101, 2'b11, 1'b0, S_LC,   C_LC | C_AS | C_LS);
    add(3'b101, 2'b11, 1'b0, S_WOUT, C_WRT | C_VC | C_NRD);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].r, tbl[i].opc, tbl[i].op, tbl[i].cnd, tbl[i].rdy,
           tbl[i].es, tbl[i].ec, $sformatf("vec%0d", i));

    // Memory write timeout: sixteen not-ready cycles, then sticky fault.
    str_prefix("to");
    for (int i = 0; i < 16; i++) st(1'b0, S_MWR, C_WR, $sformatf("to_wait%0d", i));
    for (int i = 0; i < 3; i++) st(1'b1, S_FAULT, C_FTO, $sformatf("to_fault%0d", i));
    do_reset(S_FAULT, C_FTO, "to");

    // Ready on the final allowed cycle completes normally.
    str_prefix("edge");
    for (int i = 0; i < 15; i++) st(1'b0, S_MWR, C_WR, $sformatf("edge_wait%0d", i));
    st(1'b1, S_MWR, C_WR, "edge_last");

    // Illegal opcode 000.
    fetch(3'b000, 2'b00, "ill");
    for (int i = 0; i < 3; i++) st(1'b1, S_FAULT, C_FIL, $sformatf("ill_fault%0d", i));
    do_reset(S_FAULT, C_FIL, "ill");

    // HALT absorbs for 20 cycles regardless of mem_ready.
    fetch(3'b111, 2'b00, "hlt");
    for (int i = 0; i < 20; i++) st(i[0], S_HALT, C_HLT, $sformatf("hlt%0d", i));
    do_reset(S_HALT, C_HLT, "hlt");

    // Reset dominates a pending memory read.
    fetch(3'b011, 2'b00, "rdr");
    st(1'b0, S_LA,   C_LA | C_NRN, "rdr_la");
    st(1'b0, S_LC,   C_LC | C_BS,  "rdr_lc");
    st(1'b0, S_LADR, C_LADR,       "rdr_ladr");
    st(1'b0, S_MRD,  C_RD,         "rdr_wait0");
    st(1'b0, S_MRD,  C_RD,         "rdr_wait1");
    do_reset(S_MRD, C_RD, "rdr");

`ifdef CTRL_BRANCH_EN
    cur_cnd = 1'b1;
    fetch(3'b001, 2'b00, "bt");
    st(1'b0, S_BR, C_LPC | C_PCB, "bt_br");
    cur_cnd = 1'b0;
    fetch(3'b001, 2'b00, "bn");
    st(1'b0, S_BR, C_NONE, "bn_br");
    st(1'b1, S_IF1, C_RD | C_ASRC | C_LIR, "bn_if1");
`else
    cur_cnd = 1'b1;
    fetch(3'b001, 2'b00, "b");
    st(1'b0, S_FAULT, C_FIL, "b_fault");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
